// File: rtl/can_frame_sequencer.sv
// can_frame_sequencer: tracks which CAN frame field each sampled bit belongs to and latches IDE/RTR/DLC.
// Extended-frame fields (ID_B, RTR_EXT, R1) are built only when CAN_EXT_FRAME_EN is defined.
module can_frame_sequencer #(
    parameter int SIZE_W  = 10,
    parameter int EOF_LEN = 7,
    parameter int IFS_LEN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sp,
    input  logic              isStuff,
    input  logic              rx_bit,
    output logic [3:0]        field,
    output logic [SIZE_W-1:0] frame_size,
    output logic              ide,
    output logic              rtr,
    output logic [3:0]        dlc,
    output logic              crc_en,
    output logic              stuff_en,
    output logic              frame_done,
    output logic              form_error
);
    typedef enum logic [3:0] {
        F_IDLE    = 4'd0,  F_ID_A    = 4'd1,  F_SRR_RTR = 4'd2,  F_IDE     = 4'd3,
        F_ID_B    = 4'd4,  F_RTR_EXT = 4'd5,  F_R1      = 4'd6,  F_R0      = 4'd7,
        F_DLC     = 4'd8,  F_DATA    = 4'd9,  F_CRC     = 4'd10, F_CRC_DEL = 4'd11,
        F_ACK     = 4'd12, F_ACK_DEL = 4'd13, F_EOF     = 4'd14, F_IFS     = 4'd15
    } field_t;

    field_t            field_r;
    logic [6:0]        cnt_r;
    logic [SIZE_W-1:0] size_r;
    logic              rtr_r;
    logic [3:0]        dlc_r;
    logic [2:0]        dlc_sh_r;
    logic              done_r;
    logic              ferr_r;
`ifdef CAN_EXT_FRAME_EN
    logic              ide_r;
`endif

    logic              sof_s;
    logic              consume_s;
    logic              chk_s;
    logic              ide_err_s;
    logic              err_s;
    logic              last_s;
    logic [6:0]        len_s;
    logic [SIZE_W-1:0] size_nxt_s;

    // Number of consumed bits in a field; DATA length depends on the latched DLC.
    function automatic logic [6:0] field_len(input field_t f, input logic [3:0] d);
        logic [6:0] n;
        case (f)
            F_ID_A:  n = 7'd11;
            F_ID_B:  n = 7'd18;
            F_DLC:   n = 7'd4;
            F_DATA:  n = d[3] ? 7'd64 : {1'b0, d[2:0], 3'b000};
            F_CRC:   n = 7'd15;
            F_EOF:   n = 7'(EOF_LEN);
            F_IFS:   n = 7'(IFS_LEN);
            default: n = 7'd1;
        endcase
        return n;
    endfunction

    assign sof_s      = (field_r == F_IDLE) && sp && !rx_bit;
    assign stuff_en   = sof_s || ((field_r >= F_ID_A) && (field_r <= F_CRC));
    assign crc_en     = sof_s || ((field_r >= F_ID_A) && (field_r <= F_DATA));
    assign consume_s  = sp && !(isStuff && stuff_en);
    assign chk_s      = (field_r == F_CRC_DEL) || (field_r == F_ACK_DEL) ||
                        (field_r == F_EOF) || (field_r == F_IFS);
`ifdef CAN_EXT_FRAME_EN
    assign ide_err_s  = 1'b0;
`else
    assign ide_err_s  = (field_r == F_IDE) && rx_bit;
`endif
    assign err_s      = consume_s && ((chk_s && !rx_bit) || ide_err_s);
    assign len_s      = field_len(field_r, dlc_r);
    assign last_s     = (cnt_r == (len_s - 7'd1));
    assign size_nxt_s = (&size_r) ? size_r : size_r + SIZE_W'(1);

    // Field sequencer: advances on every consumed bit, counts frame bits and latches control fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            field_r  <= F_IDLE;
            cnt_r    <= 7'd0;
            size_r   <= '0;
            rtr_r    <= 1'b0;
            dlc_r    <= 4'd0;
            dlc_sh_r <= 3'd0;
            done_r   <= 1'b0;
            ferr_r   <= 1'b0;
`ifdef CAN_EXT_FRAME_EN
            ide_r    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            ferr_r <= 1'b0;
            if (err_s) begin
                ferr_r  <= 1'b1;
                field_r <= F_IDLE;
                cnt_r   <= 7'd0;
            end else if (consume_s) begin
                if (field_r == F_IDLE) begin
                    if (!rx_bit) begin
                        field_r <= F_ID_A;
                        size_r  <= SIZE_W'(1);
                        cnt_r   <= 7'd0;
                    end
                end else begin
                    if (field_r != F_IFS) begin
                        size_r <= size_nxt_s;
                    end
                    cnt_r <= last_s ? 7'd0 : cnt_r + 7'd1;
                    case (field_r)
                        F_ID_A:    if (last_s) field_r <= F_SRR_RTR;
                        F_SRR_RTR: begin
                            rtr_r   <= rx_bit;
                            field_r <= F_IDE;
                        end
                        F_IDE: begin
`ifdef CAN_EXT_FRAME_EN
                            ide_r   <= rx_bit;
                            field_r <= rx_bit ? F_ID_B : F_R0;
`else
                            field_r <= F_R0;
`endif
                        end
`ifdef CAN_EXT_FRAME_EN
                        F_ID_B:    if (last_s) field_r <= F_RTR_EXT;
                        F_RTR_EXT: begin
                            rtr_r   <= rx_bit;
                            field_r <= F_R1;
                        end
                        F_R1:      field_r <= F_R0;
`endif
                        F_R0:      field_r <= F_DLC;
                        F_DLC: begin
                            dlc_sh_r <= {dlc_sh_r[1:0], rx_bit};
                            if (last_s) begin
                                dlc_r   <= {dlc_sh_r, rx_bit};
                                field_r <= (!rtr_r && ({dlc_sh_r, rx_bit} != 4'd0)) ? F_DATA : F_CRC;
                            end
                        end
                        F_DATA:    if (last_s) field_r <= F_CRC;
                        F_CRC:     if (last_s) field_r <= F_CRC_DEL;
                        F_CRC_DEL: field_r <= F_ACK;
                        F_ACK:     field_r <= F_ACK_DEL;
                        F_ACK_DEL: field_r <= F_EOF;
                        F_EOF: begin
                            if (last_s) begin
                                field_r <= F_IFS;
                                done_r  <= 1'b1;
                            end
                        end
                        F_IFS:     if (last_s) field_r <= F_IDLE;
                        default:   field_r <= F_IDLE;
                    endcase
                end
            end
        end
    end

    assign field      = field_r;
    assign frame_size = size_r;
    assign rtr        = rtr_r;
    assign dlc        = dlc_r;
    assign frame_done = done_r;
    assign form_error = ferr_r;
`ifdef CAN_EXT_FRAME_EN
    assign ide        = ide_r;
`else
    assign ide        = 1'b0;
`endif

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Scoreboard bench for can_frame_sequencer: frames are laid out field by field from the CAN format,
// driven with random stuff bits and sp gaps, and checked per bit (field) and per frame event.
`timescale 1ns/1ps
module tb_can_frame_sequencer;
    localparam int SIZE_W  = 10;
    localparam int EOF_LEN = 7;
    localparam int IFS_LEN = 3;
`ifdef CAN_EXT_FRAME_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              sp;
    logic              isStuff;
    logic              rx_bit;
    logic [3:0]        field;
    logic [SIZE_W-1:0] frame_size;
    logic              ide;
    logic              rtr;
    logic [3:0]        dlc;
    logic              crc_en;
    logic              stuff_en;
    logic              frame_done;
    logic              form_error;

    typedef struct {
        int kind;   // 1 = frame_done, 2 = form_error
        int size;
        bit ide;
        bit rtr;
        int dlc;
    } ev_t;

    int  fq[$];
    ev_t eq[$];
    bit  fb[$];
    int  fl[$];
    int  compared   = 0;
    int  mismatched = 0;
    bit  sp_seen    = 1'b0;

    always #5 clk = ~clk;

    can_frame_sequencer #(.SIZE_W(SIZE_W), .EOF_LEN(EOF_LEN), .IFS_LEN(IFS_LEN)) dut (
        .clk(clk), .reset(reset), .sp(sp), .isStuff(isStuff), .rx_bit(rx_bit),
        .field(field), .frame_size(frame_size), .ide(ide), .rtr(rtr), .dlc(dlc),
        .crc_en(crc_en), .stuff_en(stuff_en), .frame_done(frame_done), .form_error(form_error)
    );

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_field"}, int'(field), 0);
        check({tag, "_frame_size"}, int'(frame_size), 0);
        check({tag, "_ide"}, int'(ide), 0);
        check({tag, "_rtr"}, int'(rtr), 0);
        check({tag, "_dlc"}, int'(dlc), 0);
        check({tag, "_crc_en"}, int'(crc_en), 0);
        check({tag, "_stuff_en"}, int'(stuff_en), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_form_error"}, int'(form_error), 0);
    endtask

    always @(posedge clk) sp_seen <= sp;

    // Monitor: one field expectation per sampled bit, one event per completion/error pulse.
    always @(negedge clk) begin
        if (sp_seen) begin
            if (fq.size() == 0) check("field_unexpected_bit", 1, 0);
            else check("field", int'(field), fq.pop_front());
        end
        if (frame_done || form_error) begin
            if (eq.size() == 0) begin
                check("event_unexpected", int'(frame_done) + 2 * int'(form_error), 0);
            end else begin
                ev_t e;
                e = eq.pop_front();
                check("event_kind", frame_done ? 1 : 2, e.kind);
                check("pulse_exclusive", int'(frame_done & form_error), 0);
                check("event_frame_size", int'(frame_size), e.size);
                if (e.kind == 1) begin
                    check("ide", int'(ide), int'(e.ide));
                    check("rtr", int'(rtr), int'(e.rtr));
                    check("dlc", int'(dlc), e.dlc);
                end
            end
        end
    end

    task automatic send(input bit b, input bit st);
        sp = 1'b1; rx_bit = b; isStuff = st;
        @(posedge clk); #1;
        sp = 1'b0; rx_bit = 1'($urandom); isStuff = 1'($urandom);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic add_field(input longint unsigned v, input int n, input int lab);
        for (int j = n - 1; j >= 0; j--) begin
            fb.push_back(bit'((v >> j) & 64'd1));
            fl.push_back(lab);
        end
    endtask

    task automatic idle_bits(input int n);
        for (int k = 0; k < n; k++) begin
            fq.push_back(0);
            send(1'b1, 1'($urandom));
        end
    endtask

    // Lay out one frame as (bit, field) pairs, then drive it; err_field/err_off pick a forced
    // dominant bit, cut_field/cut_off stop the frame before that bit.
    task automatic run_frame(input bit ext, input int id, input bit rtr_b, input int dlc_v,
                             input int stuff_pct, input bit force_stuff,
                             input int err_field, input int err_off,
                             input int cut_field, input int cut_off);
        int ndata;
        int err_i;
        int cut_i;
        int total;
        fb.delete(); fl.delete();
        add_field(0, 1, 0);
        if (!ext) begin
            add_field(longint'(id), 11, 1);
            add_field(longint'(rtr_b), 1, 2);
            add_field(0, 1, 3);
        end else begin
            add_field(longint'(id >> 18), 11, 1);
            add_field(1, 1, 2);
            add_field(1, 1, 3);
            add_field(longint'(id), 18, 4);
            add_field(longint'(rtr_b), 1, 5);
            add_field(0, 1, 6);
        end
        add_field(0, 1, 7);
        add_field(longint'(dlc_v), 4, 8);
        ndata = rtr_b ? 0 : 8 * ((dlc_v > 8) ? 8 : dlc_v);
        for (int k = 0; k < ndata; k++) add_field(longint'($urandom % 2), 1, 9);
        add_field(longint'($urandom), 15, 10);
        add_field(1, 1, 11);
        add_field(longint'($urandom % 2), 1, 12);
        add_field(1, 1, 13);
        for (int k = 0; k < EOF_LEN; k++) add_field(1, 1, 14);
        for (int k = 0; k < IFS_LEN; k++) add_field(1, 1, 15);

        total = 0;
        foreach (fl[k]) if (fl[k] != 15) total++;
        err_i = -1;
        cut_i = -1;
        for (int k = 0; k < fl.size(); k++) begin
            if (err_i < 0 && err_field != 0 && fl[k] == err_field) err_i = k + err_off;
            if (cut_i < 0 && cut_field != 0 && fl[k] == cut_field) cut_i = k + cut_off;
            if (!EXT && ext && fl[k] == 3) err_i = k;
        end
        if (err_i >= 0 && !(!EXT && ext)) fb[err_i] = 1'b0;

        for (int i = 0; i < fb.size(); i++) begin
            int nxt;
            int sz;
            if (i == cut_i) break;
            if (i > 0 && fl[i] >= 1 && fl[i] <= 10 &&
                ((int'($urandom % 100) < stuff_pct) ||
                 (force_stuff && (i == 3 || (fl[i] == 9 && fl[i-1] != 9))))) begin
                fq.push_back(fl[i]);
                send(1'($urandom), 1'b1);
            end
            if (i == err_i) begin
                sz = 0;
                for (int j = 0; j < i; j++) if (fl[j] != 15) sz++;
                fq.push_back(0);
                eq.push_back('{kind: 2, size: sz, ide: 1'b0, rtr: 1'b0, dlc: 0});
                send(fb[i], 1'b0);
                break;
            end
            nxt = (i + 1 < fb.size()) ? fl[i+1] : 0;
            if (fl[i] == 14 && nxt == 15)
                eq.push_back('{kind: 1, size: total, ide: ext & EXT, rtr: rtr_b, dlc: dlc_v});
            fq.push_back(nxt);
            send(fb[i], (fl[i] >= 11) ? 1'($urandom) : 1'b0);
        end
    endtask

    initial begin
        int ef;
        int eo;
        reset = 1'b0; sp = 1'b0; isStuff = 1'b0; rx_bit = 1'b1;
        #12;
        check_zero("reset");
        #10 reset = 1'b1;
        @(posedge clk); #1;

        run_frame(1'b0, 'h123, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
        idle_bits(2);
        run_frame(1'b0, int'($urandom), 1'b0, 8, 0, 1'b1, 0, 0, 0, 0);
        run_frame(1'b1, 'h1234567, 1'b0, 2, 0, 1'b0, 0, 0, 0, 0);
        run_frame(1'b0, 'h2a5, 1'b1, 5, 0, 1'b0, 0, 0, 0, 0);
        run_frame(1'b0, 'h321, 1'b0, 1, 0, 1'b0, 14, 3, 0, 0);
        idle_bits(1);

        for (int n = 0; n < 40; n++) begin
            ef = 0; eo = 0;
            if ($urandom % 4 == 0) begin
                case ($urandom % 4)
                    0: ef = 11;
                    1: ef = 13;
                    2: begin ef = 14; eo = $urandom_range(0, EOF_LEN - 1); end
                    default: begin ef = 15; eo = $urandom_range(0, IFS_LEN - 1); end
                endcase
            end
            run_frame(1'($urandom), int'($urandom), 1'($urandom), $urandom_range(0, 15),
                      10, 1'b0, ef, eo, 0, 0);
            idle_bits($urandom_range(0, 2));
        end

        // Reset in the middle of DATA, between clock edges.
        run_frame(1'b0, 'h0f0, 1'b0, 8, 0, 1'b0, 0, 0, 9, 20);
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        check_zero("midframe_reset");
        @(negedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        fq.push_back(1);
        send(1'b0, 1'b0);
        check("restart_frame_size", int'(frame_size), 1);

        repeat (3) @(posedge clk);
        check("field_queue_drained", fq.size(), 0);
        check("events_missing", eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/can_frame_sequencer.md
Name: can_frame_sequencer

Overview:
- Sequences the CAN frame-maker datapath by tracking which frame field the current bit belongs to.
- Driven by the sample-point strobe and the stuff-bit flag. Stuff bits are skipped.
- Produces the de-stuffed frame size, the field code, the latched control fields (IDE, RTR, DLC), and the enables for the CRC and stuff-check units.
- Sits between the bit-timing / destuff logic and the CRC / frame-assembly logic.

Parameters:
- SIZE_W, 10: width of the frame_size counter.
- EOF_LEN, 7: number of recessive end-of-frame bits.
- IFS_LEN, 3: number of recessive intermission bits.

Ports:
- clk, in, 1: system clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- sp, in, 1: sample-point strobe, one-cycle pulse per bit.
- isStuff, in, 1: the bit sampled at this sp is a stuff bit.
- rx_bit, in, 1: sampled bit value (0 = dominant).
- field, out, 4: current field code (see Behaviour).
- frame_size, out, SIZE_W: de-stuffed bit count from SOF.
- ide, out, 1: latched IDE bit.
- rtr, out, 1: latched RTR bit.
- dlc, out, 4: latched DLC.
- crc_en, out, 1: the current bit feeds the CRC.
- stuff_en, out, 1: the stuff rule is active for the current bit.
- frame_done, out, 1: one-cycle pulse at the end of EOF.
- form_error, out, 1: one-cycle pulse on a fixed-form violation.

Behaviour:
- Field codes:
  - 0 IDLE, 1 ID_A, 2 SRR_RTR, 3 IDE, 4 ID_B, 5 RTR_EXT, 6 R1, 7 R0
  - 8 DLC, 9 DATA, 10 CRC, 11 CRC_DEL, 12 ACK, 13 ACK_DEL, 14 EOF, 15 IFS
- Reset (async, reset=0):
  - field=IDLE; frame_size, ide, rtr, dlc, bit counter = 0.
  - crc_en=0, stuff_en=0, frame_done=0, form_error=0.
  - Takes effect mid-frame with no completion pulse.
- Bit consumption:
  - All state changes occur on the clk rising edge with sp=1.
  - With sp=1, isStuff=1 and stuff_en=1: no field advance, no frame_size increment, bit discarded.
  - isStuff is ignored when stuff_en=0.
- Leaving IDLE:
  - sp with rx_bit=0 is SOF: frame_size<=1, bit counter cleared, field<=ID_A.
  - rx_bit=1 in IDLE: no change.
- Field lengths (consumed bits):
  - ID_A 11, SRR_RTR 1, IDE 1, ID_B 18, RTR_EXT 1, R1 1, R0 1, DLC 4.
  - DATA 8*min(dlc,8), CRC 15, CRC_DEL 1, ACK 1, ACK_DEL 1, EOF EOF_LEN, IFS IFS_LEN.
- Branches:
  - IDE: ide<=rx_bit. If 0, next field is R0 and rtr takes the SRR_RTR bit. If 1, next field is ID_B, and rtr is taken in RTR_EXT.
  - DLC: shifted in MSB first and latched after the 4th bit.
  - After DLC: go to DATA if rtr=0 and dlc!=0, otherwise go to CRC.
- frame_size:
  - Increments by 1 on every consumed non-stuff bit from SOF through the last EOF bit.
  - Saturates at all-ones.
  - Holds its value through IFS/IDLE until the next SOF.
- frame_done:
  - Pulses on the cycle the last EOF bit is consumed.
  - field moves to IFS.
  - After IFS_LEN recessive bits, field returns to IDLE.
- form_error:
  - Pulses when rx_bit=0 in CRC_DEL, ACK_DEL, EOF or IFS.
  - field goes to IDLE on the same edge.
  - frame_size holds; frame_done does not pulse.
- Combinational outputs from field:
  - crc_en=1 for field in {SOF bit (IDLE with sp & !rx_bit), 1..9}.
  - stuff_en=1 for the SOF bit and fields 1..10.
- ACK:
  - Either bit value is accepted in ACK.
  - The ACK bit value is not checked.

Optional Feature:
- Macro: CAN_EXT_FRAME_EN.
- Defined: extended frames are supported as described above.
- Undefined:
  - States ID_B, RTR_EXT and R1 are not built.
  - ide=1 in the IDE field causes a form_error pulse and a return to IDLE.
  - The ide output is tied to 0.

Test Plan:
- Base frame, ID 0x123, RTR=0, DLC=0, no stuff bits, valid delimiters → DATA skipped; frame_done pulses once; frame_size=44; field=IFS then IDLE after 3 bits.
- Base frame, DLC=8, two stuff bits injected (sp&isStuff) inside ID_A and DATA → frame_size=108; dlc=8; no extra field advance on the stuff bits.
- Extended frame (macro defined), DLC=2 → ide=1; frame_size=80; field sequence visits 4, 5, 6.
- Base frame with RTR=1, DLC=5 → DATA skipped; frame_size=44; dlc=5.
- Dominant bit in EOF bit 4 → form_error one-cycle pulse; field=IDLE; no frame_done.
- reset asserted mid-DATA → all outputs 0 immediately (async); the next dominant sp starts a new frame with frame_size=1.
